// File: rtl/pac_dispatch_if.sv
// Packet/action ingress from pfw and the three egress port buses of pac_dispatch.
// slave faces the dispatcher; master faces the packet source and egress sinks.
interface pac_dispatch_if;
    logic [133:0] in_pac_data;
    logic         in_pac_data_wr;
    logic         in_pac_valid;
    logic         in_pac_valid_wr;
    logic [10:0]  in_pac_action;
    logic         in_pac_action_wr;
    logic         in_p0_alf;
    logic         in_p1_alf;
    logic         in_p2_alf;
    logic [133:0] out_p0_data;
    logic         out_p0_data_wr;
    logic         out_p0_valid;
    logic         out_p0_valid_wr;
    logic [133:0] out_p1_data;
    logic         out_p1_data_wr;
    logic         out_p1_valid;
    logic         out_p1_valid_wr;
    logic [133:0] out_p2_data;
    logic         out_p2_data_wr;
    logic         out_p2_valid;
    logic         out_p2_valid_wr;
    logic [31:0]  out_drop_cnt;

    modport slave (
        input  in_pac_data, in_pac_data_wr, in_pac_valid, in_pac_valid_wr,
        input  in_pac_action, in_pac_action_wr,
        input  in_p0_alf, in_p1_alf, in_p2_alf,
        output out_p0_data, out_p0_data_wr, out_p0_valid, out_p0_valid_wr,
        output out_p1_data, out_p1_data_wr, out_p1_valid, out_p1_valid_wr,
        output out_p2_data, out_p2_data_wr, out_p2_valid, out_p2_valid_wr,
        output out_drop_cnt
    );

    modport master (
        output in_pac_data, in_pac_data_wr, in_pac_valid, in_pac_valid_wr,
        output in_pac_action, in_pac_action_wr,
        output in_p0_alf, in_p1_alf, in_p2_alf,
        input  out_p0_data, out_p0_data_wr, out_p0_valid, out_p0_valid_wr,
        input  out_p1_data, out_p1_data_wr, out_p1_valid, out_p1_valid_wr,
        input  out_p2_data, out_p2_data_wr, out_p2_valid, out_p2_valid_wr,
        input  out_drop_cnt
    );
endinterface

// File: rtl/pac_dispatch.sv
// Packet dispatcher: buffers pfw packets, commits them on the trailer and
// replays them to egress port 0, port 1 and/or the direct port 2.
module pac_dispatch #(
    parameter int DATA_AW       = 9,
    parameter int DESC_AW       = 4,
    parameter int MAX_PKT_WORDS = 128
) (
    input logic           clk,
    input logic           rst_n,
    pac_dispatch_if.slave bus
);
    localparam int DEPTH = 1 << DATA_AW;
    localparam int LW    = $clog2(MAX_PKT_WORDS + 1);

    typedef struct packed {
        logic [LW-1:0] len;
        logic          ok;
        logic [2:0]    dest;
    } desc_t;

    typedef enum logic [1:0] {W_IDLE, W_STORE, W_DROP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_SEND, R_DROP} rstate_t;

    // {routable, dest[2:0]}; dest bit n selects egress port n
    function automatic logic [3:0] route(input logic [10:0] a);
        logic [3:0] r;
        r = '0;
        unique case (1'b1)
            a[10:9] == 2'b00 && a[5:0] < 6'd3:
                r = {1'b1, 3'(3'b001 << a[1:0])};
            a[10:9] == 2'b10:
                r = {1'b1, 1'b1, a[0], ~a[0]};
            default: r = '0;
        endcase
        return r;
    endfunction

    logic [133:0]     mem [DEPTH];
    desc_t            dmem [2**DESC_AW];

    wstate_t          ws, ws_nx;
    rstate_t          rs, rs_nx;
    logic [DATA_AW:0] wp, wp_nx, wbase, wbase_nx, rp, rp_nx, used;
    logic [DESC_AW:0] dwp, drp;
    logic [LW-1:0]    wlen, wlen_nx, rlen, rlen_nx;
    logic [2:0]       rdest, rdest_nx, alf;
    logic [10:0]      act, act_cur;
    logic [3:0]       rt;
    logic             head, tail, room, dfull, dempty;
    logic             we, push, pop, w_drop, r_drop, send, last;
    logic             may_start;
    desc_t            din, dh;
    logic [133:0]     rword;
    logic [2:0][133:0] od;
    logic [2:0]       odw, ov;
    logic [31:0]      drop_cnt;

    assign head    = bus.in_pac_data_wr && bus.in_pac_data[133:132] == 2'b01;
    assign tail    = bus.in_pac_data_wr && bus.in_pac_valid_wr;
    assign used    = wp - rp;
    assign room    = int'(used) <= DEPTH - MAX_PKT_WORDS;
    assign dfull   = dwp[DESC_AW] != drp[DESC_AW]
                  && dwp[DESC_AW-1:0] == drp[DESC_AW-1:0];
    assign dempty  = dwp == drp;
    assign act_cur = bus.in_pac_action_wr ? bus.in_pac_action : act;
    assign rt      = route(act_cur);
    assign din     = '{len: wlen_nx, ok: bus.in_pac_valid & rt[3], dest: rt[2:0]};
    assign dh      = dmem[drp[DESC_AW-1:0]];
    assign alf     = {bus.in_p2_alf, bus.in_p1_alf, bus.in_p0_alf};
    assign rword   = mem[rp[DATA_AW-1:0]];
    assign last    = rlen == LW'(1);

    always_comb begin
        ws_nx    = ws;
        wp_nx    = wp;
        wbase_nx = wbase;
        wlen_nx  = wlen;
        we       = 1'b0;
        push     = 1'b0;
        w_drop   = 1'b0;
        unique case (ws)
            W_IDLE: begin
                if (head && room && !dfull) begin
                    we       = 1'b1;
                    wp_nx    = wp + 1'b1;
                    wbase_nx = wp;
                    wlen_nx  = LW'(1);
                    if (tail) push = 1'b1;
                    else      ws_nx = W_STORE;
                end else if (head) begin
                    if (tail) w_drop = 1'b1;
                    else      ws_nx  = W_DROP;
                end
            end
            W_STORE: begin
                if (bus.in_pac_data_wr && wlen == LW'(MAX_PKT_WORDS)) begin
                    // oversize: roll back the uncommitted words
                    wp_nx  = wbase;
                    w_drop = tail;
                    ws_nx  = tail ? W_IDLE : W_DROP;
                end else if (bus.in_pac_data_wr) begin
                    we      = 1'b1;
                    wp_nx   = wp + 1'b1;
                    wlen_nx = wlen + 1'b1;
                    if (tail) begin
                        push  = 1'b1;
                        ws_nx = W_IDLE;
                    end
                end
            end
            W_DROP: begin
                if (tail) begin
                    w_drop = 1'b1;
                    ws_nx  = W_IDLE;
                end
            end
            default: ws_nx = W_IDLE;
        endcase
    end

    always_comb begin
        rs_nx     = rs;
        rp_nx     = rp;
        rlen_nx   = rlen;
        rdest_nx  = rdest;
        pop       = 1'b0;
        send      = 1'b0;
        r_drop    = 1'b0;
        may_start = 1'b0;
        unique case (rs)
            R_IDLE: may_start = 1'b1;
            R_SEND, R_DROP: begin
                rp_nx   = rp + 1'b1;
                rlen_nx = rlen - 1'b1;
                send    = rs == R_SEND;
                if (last) begin
                    r_drop    = rs == R_DROP;
                    rs_nx     = R_IDLE;
                    may_start = 1'b1;
                end
            end
            default: rs_nx = R_IDLE;
        endcase
        // alf only gates the start of a packet, never its body
        if (may_start && !dempty) begin
            if (!dh.ok) begin
                pop     = 1'b1;
                rs_nx   = R_DROP;
                rlen_nx = dh.len;
            end else if ((dh.dest & alf) == 3'b000) begin
                pop      = 1'b1;
                rs_nx    = R_SEND;
                rlen_nx  = dh.len;
                rdest_nx = dh.dest;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we)   mem[wp[DATA_AW-1:0]]   <= bus.in_pac_data;
        if (push) dmem[dwp[DESC_AW-1:0]] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ws       <= W_IDLE;
            rs       <= R_IDLE;
            wp       <= '0;
            wbase    <= '0;
            rp       <= '0;
            dwp      <= '0;
            drp      <= '0;
            wlen     <= '0;
            rlen     <= '0;
            rdest    <= '0;
            act      <= '0;
            od       <= '0;
            odw      <= '0;
            ov       <= '0;
            drop_cnt <= '0;
        end else begin
            ws       <= ws_nx;
            rs       <= rs_nx;
            wp       <= wp_nx;
            wbase    <= wbase_nx;
            rp       <= rp_nx;
            wlen     <= wlen_nx;
            rlen     <= rlen_nx;
            rdest    <= rdest_nx;
            act      <= act_cur;
            dwp      <= dwp + {{DESC_AW{1'b0}}, push};
            drp      <= drp + {{DESC_AW{1'b0}}, pop};
            drop_cnt <= drop_cnt + {31'b0, w_drop} + {31'b0, r_drop};
            for (int n = 0; n < 3; n++) begin
                od[n]  <= (send && rdest[n]) ? rword : '0;
                odw[n] <= send && rdest[n];
                ov[n]  <= send && rdest[n] && last;
            end
        end
    end

    assign bus.out_p0_data     = od[0];
    assign bus.out_p0_data_wr  = odw[0];
    assign bus.out_p0_valid    = ov[0];
    assign bus.out_p0_valid_wr = ov[0];
    assign bus.out_p1_data     = od[1];
    assign bus.out_p1_data_wr  = odw[1];
    assign bus.out_p1_valid    = ov[1];
    assign bus.out_p1_valid_wr = ov[1];
    assign bus.out_p2_data     = od[2];
    assign bus.out_p2_data_wr  = odw[2];
    assign bus.out_p2_valid    = ov[2];
    assign bus.out_p2_valid_wr = ov[2];
    assign bus.out_drop_cnt    = drop_cnt;
endmodule
